// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// inst_fetch_queue : sequential instruction fetch over a req/ack memory port,
//                    buffering {inst, pc} in a DEPTH-entry FIFO for decode.
// Revision 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h100000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [29:0] redirect_pc
);

    localparam int              c_PW      = $clog2(DEPTH);
    localparam int              c_CW      = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [1:0]      c_ST_IDLE = 2'd0;
    localparam logic [1:0]      c_ST_WAIT = 2'd1;
    localparam logic [1:0]      c_ST_DROP = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic [29:0]     fetch_pc_q, fetch_pc_d;
    logic [29:0]     req_addr_q, req_addr_d;
    logic [c_PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [c_PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_CW-1:0] count_q,    count_d;
    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     inst_mem_d [DEPTH];
    logic [29:0]     pc_mem_q   [DEPTH];
    logic [29:0]     pc_mem_d   [DEPTH];

    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic            w_room;
    logic            w_issue;
    logic [c_CW-1:0] w_count_next;

    assign mem_req    = (state_q == c_ST_WAIT) || (state_q == c_ST_DROP);
    assign mem_addr   = req_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];

    // Data returned in DROP belongs to a request issued before a redirect.
    assign w_ack        = mem_req && mem_ack;
    assign w_push       = w_ack && (state_q == c_ST_WAIT);
    assign w_pop        = inst_valid && inst_ready;
    assign w_count_next = count_q - c_CW'(w_pop) + c_CW'(w_push);
    assign w_room       = (w_count_next < c_DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        w_issue    = 1'b0;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if ((state_q == c_ST_IDLE) || w_ack) begin
                req_addr_d = redirect_pc;
                fetch_pc_d = redirect_pc + 30'd1;
                state_d    = c_ST_WAIT;
            end else begin
                // Old request stays on the bus until acked; its data is dropped.
                fetch_pc_d = redirect_pc;
                state_d    = c_ST_DROP;
            end
        end else begin
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PW'(1);
            end
            if (w_push) begin
                inst_mem_d[wr_ptr_q] = mem_rdata;
                pc_mem_d[wr_ptr_q]   = req_addr_q;
                wr_ptr_d             = wr_ptr_q + c_PW'(1);
            end
            count_d = w_count_next;

            // A new request is only issued when a free slot can be reserved.
            case (state_q)
                c_ST_IDLE: begin
                    w_issue = (count_q < c_DEPTH);
                end
                c_ST_WAIT: begin
                    if (w_ack) begin
                        if (w_room) begin
                            w_issue = 1'b1;
                        end else begin
                            state_d = c_ST_IDLE;
                        end
                    end
                end
                c_ST_DROP: begin
                    w_issue = w_ack;
                end
                default: begin
                    state_d = c_ST_IDLE;
                end
            endcase

            if (w_issue) begin
                req_addr_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 30'd1;
                state_d    = c_ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= c_ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_queue : vector table, directed corner sequences and a random
//                       run against a queue-based fetch model.
// Revision 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [29:0] RESET_PC = 30'h100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [29:0] redirect_pc;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [29:0] rpc;
        logic        e_req;
        logic [29:0] e_addr;
        logic        e_valid;
        logic [29:0] e_pc;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic ack, input logic rdy, input logic redir,
                                input logic [29:0] rpc, input logic e_req,
                                input logic [29:0] e_addr, input logic e_valid,
                                input logic [29:0] e_pc);
        vec_t v;
        v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a queue of fetched words plus one outstanding request
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] inst;
        logic [29:0] pc;
    } entry_t;

    entry_t      fq [$];
    bit          m_req;
    bit          m_stale;
    logic [29:0] m_addr;
    logic [29:0] m_next;

    int          wait_cnt;
    int          cur_lat;
    int          fixed_lat = 0;
    bit          rand_lat  = 1'b0;
    bit          ack_noise = 1'b0;
    logic [31:0] data_xor  = 32'h0;

    logic        s_req;
    logic        s_valid;
    logic [29:0] s_addr;
    logic [29:0] s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] mem_fn(input logic [29:0] a);
        return {2'b00, a} ^ data_xor;
    endfunction

    task automatic model_issue();
        m_req  = 1'b1;
        m_addr = m_next;
        m_next = m_next + 30'd1;
    endtask

    task automatic model_edge(input bit ack_in, input bit rdy, input bit redir,
                              input logic [29:0] rpc, input logic [31:0] rdata);
        bit     ack     = m_req && ack_in;
        bit     was_req = m_req;
        int     pre     = fq.size();
        entry_t e;
        if (redir) begin
            fq.delete();
            if (!m_req || ack) begin
                m_req   = 1'b1;
                m_stale = 1'b0;
                m_addr  = rpc;
                m_next  = rpc + 30'd1;
            end else begin
                m_stale = 1'b1;
                m_next  = rpc;
            end
        end else begin
            if (pre != 0 && rdy) void'(fq.pop_front());
            if (ack && !m_stale) begin
                e.inst = rdata;
                e.pc   = m_addr;
                fq.push_back(e);
            end
            if (!was_req) begin
                if (pre < DEPTH) model_issue();
            end else if (ack) begin
                if (m_stale || fq.size() < DEPTH) model_issue();
                else m_req = 1'b0;
                m_stale = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b0;
        mem_ack    = 1'b0;
        inst_ready = 1'b0;
        redirect   = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset   = 1'b1;
        fq.delete();
        m_req    = 1'b0;
        m_stale  = 1'b0;
        m_addr   = RESET_PC;
        m_next   = RESET_PC;
        wait_cnt = 0;
        cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic run_cycle(input bit rdy, input bit redir, input logic [29:0] rpc);
        bit a;
        @(negedge clk);
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_valid = inst_valid;
        s_inst  = inst;
        s_pc    = inst_pc;
        chk("mem_req", s_req, m_req);
        if (m_req) chk("mem_addr", s_addr, m_addr);
        chk("inst_valid", s_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            chk("inst", s_inst, fq[0].inst);
            chk("inst_pc", s_pc, fq[0].pc);
        end
        if (s_req) a = (wait_cnt >= cur_lat);
        else       a = ack_noise && ($urandom_range(0, 1) == 1);
        mem_ack     = a;
        mem_rdata   = (a && s_req) ? mem_fn(s_addr) : $urandom();
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        @(posedge clk);
        model_edge(a, rdy, redir, rpc, mem_rdata);
        if (s_req && a) begin
            wait_cnt = 0;
            cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end else if (s_req) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    endtask

    int          first_v;
    int          found;
    int          hold;
    bit          stale_seen;
    logic [29:0] nxt;
    bit          r_rdy;
    bit          r_redir;
    logic [29:0] r_pc;

    initial begin
        reset       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        //           ack rdy red rpc            req addr           vld pc
        vecs[0]  = mk(0, 0, 0, 30'h0,        0, 30'h100000,   0, 30'h0);
        vecs[1]  = mk(1, 0, 0, 30'h0,        1, 30'h100000,   0, 30'h0);
        vecs[2]  = mk(1, 0, 0, 30'h0,        1, 30'h100001,   1, 30'h100000);
        vecs[3]  = mk(1, 0, 0, 30'h0,        1, 30'h100002,   1, 30'h100000);
        vecs[4]  = mk(1, 0, 0, 30'h0,        1, 30'h100003,   1, 30'h100000);
        vecs[5]  = mk(0, 1, 0, 30'h0,        0, 30'h100003,   1, 30'h100000);
        vecs[6]  = mk(0, 0, 0, 30'h0,        0, 30'h100003,   1, 30'h100001);
        vecs[7]  = mk(1, 0, 0, 30'h0,        1, 30'h100004,   1, 30'h100001);
        vecs[8]  = mk(0, 0, 0, 30'h0,        0, 30'h100004,   1, 30'h100001);
        vecs[9]  = mk(0, 1, 1, 30'h3FFFFFFF, 0, 30'h100004,   1, 30'h100001);
        vecs[10] = mk(1, 1, 0, 30'h0,        1, 30'h3FFFFFFF, 0, 30'h0);
        vecs[11] = mk(1, 1, 0, 30'h0,        1, 30'h0,        1, 30'h3FFFFFFF);
        vecs[12] = mk(0, 1, 0, 30'h0,        1, 30'h1,        1, 30'h0);
        vecs[13] = mk(0, 1, 0, 30'h0,        1, 30'h1,        0, 30'h0);
        vecs[14] = mk(1, 1, 0, 30'h0,        1, 30'h1,        0, 30'h0);
        vecs[15] = mk(0, 0, 0, 30'h0,        1, 30'h2,        1, 30'h1);

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 30'h0);

        // Table: fill to full, single-pop refill, redirect while full, pc wrap
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), mem_req, vecs[i].e_req);
            if (vecs[i].e_req || i == 0) chk($sformatf("tbl%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), inst_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), inst_pc, vecs[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), inst, {2'b00, vecs[i].e_pc});
            end
            mem_ack     = vecs[i].ack;
            mem_rdata   = {2'b00, mem_addr};
            inst_ready  = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
        end

        // Zero-wait streaming from reset, decode always ready
        fixed_lat = 0; rand_lat = 1'b0; data_xor = 32'h0;
        apply_reset();
        first_v = -1;
        for (int c = 0; c < 12; c++) begin
            run_cycle(1'b1, 1'b0, 30'h0);
            if (s_valid && first_v < 0) first_v = c;
            if (s_valid) chk("p1_inst_eq_pc", s_inst, {2'b00, s_pc});
            if (c >= 1) chk("p1_addr_seq", s_addr, RESET_PC + 30'(c - 1));
        end
        chk("p1_first_valid_cycle", first_v, 2);

        // Redirect one cycle into a 3-cycle-latency request of 100002
        fixed_lat = 3; data_xor = 32'h5555_0000;
        apply_reset();
        found = -1;
        for (int c = 0; c < 60; c++) begin
            run_cycle(1'b1, 1'b0, 30'h0);
            if (s_req && s_addr == 30'h100002) begin
                found = c;
                break;
            end
        end
        chk("p3_req_100002_seen", found >= 0, 1'b1);
        run_cycle(1'b1, 1'b1, 30'h200);
        chk("p3_addr_at_redirect", s_addr, 30'h100002);
        hold = 0; nxt = '0; stale_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            run_cycle(1'b1, 1'b0, 30'h0);
            if (s_valid && s_pc == 30'h100002) stale_seen = 1'b1;
            if (s_req && s_addr != 30'h100002) begin
                nxt = s_addr;
                break;
            end
            if (s_req) hold++;
        end
        chk("p3_hold_cycles", hold, 2);
        chk("p3_next_addr", nxt, 30'h200);
        for (int c = 0; c < 10; c++) begin
            run_cycle(1'b1, 1'b0, 30'h0);
            if (s_valid && s_pc == 30'h100002) stale_seen = 1'b1;
        end
        chk("p3_no_stale_inst", stale_seen, 1'b0);

        // Redirect coincident with ack and pop, two entries buffered
        fixed_lat = 0; data_xor = 32'h0F0F_0000;
        apply_reset();
        repeat (3) run_cycle(1'b0, 1'b0, 30'h0);
        run_cycle(1'b1, 1'b1, 30'h1234);
        chk("p4_valid_before", s_valid, 1'b1);
        chk("p4_pc_before", s_pc, RESET_PC);
        chk("p4_req_before", s_req, 1'b1);
        run_cycle(1'b1, 1'b0, 30'h0);
        chk("p4_valid_after", s_valid, 1'b0);
        chk("p4_req_after", s_req, 1'b1);
        chk("p4_addr_after", s_addr, 30'h1234);
        run_cycle(1'b1, 1'b0, 30'h0);
        chk("p4_first_valid", s_valid, 1'b1);
        chk("p4_first_pc", s_pc, 30'h1234);
        chk("p4_first_inst", s_inst, mem_fn(30'h1234));

        // Asynchronous reset in WAIT with three entries buffered
        fixed_lat = 0; data_xor = 32'hA000_0000;
        apply_reset();
        repeat (3) run_cycle(1'b0, 1'b0, 30'h0);
        fixed_lat = 5;
        run_cycle(1'b0, 1'b0, 30'h0);
        @(negedge clk);
        chk("r_pre_req", mem_req, 1'b1);
        chk("r_pre_addr", mem_addr, 30'h100003);
        chk("r_pre_valid", inst_valid, 1'b1);
        mem_ack = 1'b0;
        reset   = 1'b0;
        #1;
        chk("r_mid_req", mem_req, 1'b0);
        chk("r_mid_valid", inst_valid, 1'b0);
        chk("r_mid_inst", inst, 32'h0);
        chk("r_mid_pc", inst_pc, 30'h0);
        chk("r_mid_addr", mem_addr, RESET_PC);
        fixed_lat = 0;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            run_cycle(1'b1, 1'b0, 30'h0);
            if (c == 1) chk("r_restart_addr", s_addr, RESET_PC);
        end

        // Random traffic: variable latency, bursty decode, redirects, ack noise
        rand_lat = 1'b1; ack_noise = 1'b1; data_xor = 32'hC3C3_0F0F;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (((c / 150) % 2) == 0) r_rdy = ($urandom_range(0, 9) < 3);
            else                      r_rdy = ($urandom_range(0, 9) < 9);
            r_redir = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) r_pc = 30'h3FFFFFFE + 30'($urandom_range(0, 1));
            else                           r_pc = 30'($urandom());
            run_cycle(r_rdy, r_redir, r_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
